// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg
// Shared types and constants for the VRAM arbiter slice.
//   owner_t      : which requester a grant or returning read belongs to
//   arb_state_t  : owner of the most recent grant (IDLE when nobody was granted)
//   tag_t        : one read-return tracking entry {valid, owner}
//   MASK_ALL     : all-ones write mask, sliced to MASK_W by users
//   satInc8      : saturating increment used by the display burst counter
// Optional feature macro used by the top level: VRAM_ARB_STATS_EN
package vram_arb_pkg;

   typedef enum logic {
      OWN_DISP = 1'b0,
      OWN_GFX  = 1'b1
   } owner_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DISP = 2'd1,
      GFX  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } tag_t;

   localparam logic [31:0] MASK_ALL = 32'hFFFF_FFFF;

   // Saturating increment; never exceeds lim.
   function automatic logic [7:0] satInc8(input logic [7:0] v, input logic [7:0] lim);
      satInc8 = (v >= lim) ? lim : v + 8'd1;
   endfunction

endpackage

// File: rtl/vram_arb_tag_pipe.sv
// vram_arb_tag_pipe
// Fixed-depth shift register of read-return tags. A tag enters every cycle
// (invalid when the grant was not a read) and the tail tells the return
// stage which requester owns the word currently on vram_data_i.
// Ports:
//   clk          : system clock
//   clear_i      : synchronous clear, empties the pipeline
//   tagValid_i   : entering tag is a read
//   tagOwner_i   : entering tag owner (0 = display, 1 = graphite)
//   tagValid_o   : tail tag valid
//   tagOwner_o   : tail tag owner
module vram_arb_tag_pipe
   import vram_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic clear_i,
   input  logic tagValid_i,
   input  logic tagOwner_i,
   output logic tagValid_o,
   output logic tagOwner_o
);

   tag_t pipe_q [DEPTH];
   tag_t tagIn;

   assign tagIn.valid = tagValid_i;
   assign tagIn.owner = owner_t'(tagOwner_i);

   // Shift one stage per cycle; clearing drops every in-flight read so no
   // stale valid pulse can appear after a reset.
   always_ff @(posedge clk) begin
      if (clear_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '{valid: 1'b0, owner: OWN_DISP};
         end
      end else begin
         pipe_q[0] <= tagIn;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign tagValid_o = pipe_q[DEPTH-1].valid;
   assign tagOwner_o = pipe_q[DEPTH-1].owner;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares a single-port VRAM between the display scanout prefetch (high
// priority, read only) and the graphite rasterizer (low priority, read/write).
// At most one access is granted per cycle; the RAM command is registered and
// returned read data is steered back to the requester that issued the read.
// A display burst limit guarantees graphite one grant after MAX_DISP_BURST
// consecutive display grants while it is waiting.
// Ports:
//   clk, reset_i                    : clock, synchronous active-high reset
//   disp_req_i/addr_i, disp_ack_o   : display read request and acceptance
//   disp_valid_o, disp_data_o       : display read return
//   gfx_sel_i/wr_i/mask_i/addr_i/data_i, gfx_ack_o : graphite request
//   gfx_valid_o, gfx_data_o         : graphite read return
//   vram_sel_o/wr_o/mask_o/addr_o/data_o : registered RAM command
//   vram_data_i                     : RAM read data, READ_LATENCY after command
//   gfx_stall_cnt_o, forced_grant_cnt_o : statistics, only with VRAM_ARB_STATS_EN
// Optional feature macro: VRAM_ARB_STATS_EN
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 16,
   parameter int MASK_W         = 4,
   parameter int READ_LATENCY   = 1,
   parameter int MAX_DISP_BURST = 8
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              disp_req_i,
   input  logic [ADDR_W-1:0] disp_addr_i,
   output logic              disp_ack_o,
   output logic              disp_valid_o,
   output logic [DATA_W-1:0] disp_data_o,
   input  logic              gfx_sel_i,
   input  logic              gfx_wr_i,
   input  logic [MASK_W-1:0] gfx_mask_i,
   input  logic [ADDR_W-1:0] gfx_addr_i,
   input  logic [DATA_W-1:0] gfx_data_i,
   output logic              gfx_ack_o,
   output logic              gfx_valid_o,
   output logic [DATA_W-1:0] gfx_data_o,
   output logic              vram_sel_o,
   output logic              vram_wr_o,
   output logic [MASK_W-1:0] vram_mask_o,
   output logic [ADDR_W-1:0] vram_addr_o,
   output logic [DATA_W-1:0] vram_data_o,
   input  logic [DATA_W-1:0] vram_data_i
`ifdef VRAM_ARB_STATS_EN
   ,
   output logic [31:0]       gfx_stall_cnt_o,
   output logic [15:0]       forced_grant_cnt_o
`endif
);

   localparam logic [MASK_W-1:0] MaskAll  = MASK_ALL[MASK_W-1:0];
   localparam logic [7:0]        BurstMax = 8'(MAX_DISP_BURST);

   arb_state_t        state_q, stateD;
   logic [7:0]        burstCnt_q, burstCntD;
   logic              dispGrant, gfxGrant, forcedGrant, readGrant;

   logic              vramSel_q, vramWr_q;
   logic [MASK_W-1:0] vramMask_q;
   logic [ADDR_W-1:0] vramAddr_q;
   logic [DATA_W-1:0] vramData_q;

   logic              tailValid, tailOwner;
   logic              dispValid_q, gfxValid_q;
   logic [DATA_W-1:0] dispData_q, gfxData_q;

   // Arbitration: display wins ties until the burst counter reaches the
   // limit, then graphite gets a single forced grant and the count restarts.
   // Nothing is granted while reset is asserted.
   always_comb begin
      stateD      = state_q;
      burstCntD   = burstCnt_q;
      dispGrant   = 1'b0;
      gfxGrant    = 1'b0;
      forcedGrant = 1'b0;
      if (!reset_i) begin
         if (disp_req_i && gfx_sel_i) begin
            if (burstCnt_q >= BurstMax) begin
               gfxGrant    = 1'b1;
               forcedGrant = 1'b1;
               stateD      = GFX;
               burstCntD   = '0;
            end else begin
               dispGrant = 1'b1;
               stateD    = DISP;
               burstCntD = satInc8(burstCnt_q, BurstMax);
            end
         end else if (disp_req_i) begin
            dispGrant = 1'b1;
            stateD    = DISP;
            burstCntD = satInc8(burstCnt_q, BurstMax);
         end else if (gfx_sel_i) begin
            gfxGrant  = 1'b1;
            stateD    = GFX;
            burstCntD = '0;
         end else begin
            stateD    = IDLE;
            burstCntD = '0;
         end
      end
   end

   assign disp_ack_o = dispGrant;
   assign gfx_ack_o  = gfxGrant;
   assign readGrant  = dispGrant | (gfxGrant & ~gfx_wr_i);

   // Arbitration state and the registered RAM command. Address, mask and
   // write data hold their last values between grants; only sel/wr pulse.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q    <= IDLE;
         burstCnt_q <= '0;
         vramSel_q  <= 1'b0;
         vramWr_q   <= 1'b0;
         vramMask_q <= MaskAll;
         vramAddr_q <= '0;
         vramData_q <= '0;
      end else begin
         state_q    <= stateD;
         burstCnt_q <= burstCntD;
         vramSel_q  <= dispGrant | gfxGrant;
         vramWr_q   <= gfxGrant & gfx_wr_i;
         if (dispGrant) begin
            vramAddr_q <= disp_addr_i;
            vramMask_q <= MaskAll;
         end else if (gfxGrant) begin
            vramAddr_q <= gfx_addr_i;
            vramMask_q <= gfx_wr_i ? gfx_mask_i : MaskAll;
            if (gfx_wr_i) begin
               vramData_q <= gfx_data_i;
            end
         end
      end
   end

   assign vram_sel_o  = vramSel_q;
   assign vram_wr_o   = vramWr_q;
   assign vram_mask_o = vramMask_q;
   assign vram_addr_o = vramAddr_q;
   assign vram_data_o = vramData_q;

   // One stage for the command register plus READ_LATENCY stages for the RAM,
   // so the tail lines up with the cycle vram_data_i carries the word.
   vram_arb_tag_pipe #(
      .DEPTH(READ_LATENCY + 1)
   ) u_tagPipe (
      .clk        (clk),
      .clear_i    (reset_i),
      .tagValid_i (readGrant),
      .tagOwner_i (gfxGrant),
      .tagValid_o (tailValid),
      .tagOwner_o (tailOwner)
   );

   // Return stage: register the word for its owner; data outputs hold
   // between returns so consumers can sample them lazily.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         dispValid_q <= 1'b0;
         gfxValid_q  <= 1'b0;
         dispData_q  <= '0;
         gfxData_q   <= '0;
      end else begin
         dispValid_q <= tailValid && (owner_t'(tailOwner) == OWN_DISP);
         gfxValid_q  <= tailValid && (owner_t'(tailOwner) == OWN_GFX);
         if (tailValid && (owner_t'(tailOwner) == OWN_DISP)) begin
            dispData_q <= vram_data_i;
         end
         if (tailValid && (owner_t'(tailOwner) == OWN_GFX)) begin
            gfxData_q <= vram_data_i;
         end
      end
   end

   assign disp_valid_o = dispValid_q;
   assign disp_data_o  = dispData_q;
   assign gfx_valid_o  = gfxValid_q;
   assign gfx_data_o   = gfxData_q;

`ifdef VRAM_ARB_STATS_EN
   logic [31:0] gfxStallCnt_q;
   logic [15:0] forcedCnt_q;

   // Stall cycles and burst-limit grants, both saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         gfxStallCnt_q <= '0;
         forcedCnt_q   <= '0;
      end else begin
         if (gfx_sel_i && !gfxGrant && (gfxStallCnt_q != 32'hFFFF_FFFF)) begin
            gfxStallCnt_q <= gfxStallCnt_q + 32'd1;
         end
         if (forcedGrant && (forcedCnt_q != 16'hFFFF)) begin
            forcedCnt_q <= forcedCnt_q + 16'd1;
         end
      end
   end

   assign gfx_stall_cnt_o    = gfxStallCnt_q;
   assign forced_grant_cnt_o = forcedCnt_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Drives two arbiters (READ_LATENCY 1 and 3) with identical stimulus. Each
// has its own RAM model; a scoreboard queues the expected read word and due
// cycle at every read ack and checks each valid pulse against it.
module tb_vram_arbiter;

   localparam int AW = 14;
   localparam int DW = 16;
   localparam int MW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_i;
   logic          disp_req_i;
   logic [AW-1:0] disp_addr_i;
   logic          gfx_sel_i;
   logic          gfx_wr_i;
   logic [MW-1:0] gfx_mask_i;
   logic [AW-1:0] gfx_addr_i;
   logic [DW-1:0] gfx_data_i;

   logic          dispAck [2];
   logic          dispValid [2];
   logic [DW-1:0] dispData [2];
   logic          gfxAck [2];
   logic          gfxValid [2];
   logic [DW-1:0] gfxData [2];
   logic          vramSel [2];
   logic          vramWr [2];
   logic [MW-1:0] vramMask [2];
   logic [AW-1:0] vramAddr [2];
   logic [DW-1:0] vramDataOut [2];
   logic [DW-1:0] vramDataIn [2];
`ifdef VRAM_ARB_STATS_EN
   logic [31:0]   stallCnt [2];
   logic [15:0]   forcedCnt [2];
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   vram_arbiter #(.READ_LATENCY(1)) dut1 (
      .clk(clk), .reset_i(reset_i),
      .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_ack_o(dispAck[0]),
      .disp_valid_o(dispValid[0]), .disp_data_o(dispData[0]),
      .gfx_sel_i(gfx_sel_i), .gfx_wr_i(gfx_wr_i), .gfx_mask_i(gfx_mask_i),
      .gfx_addr_i(gfx_addr_i), .gfx_data_i(gfx_data_i), .gfx_ack_o(gfxAck[0]),
      .gfx_valid_o(gfxValid[0]), .gfx_data_o(gfxData[0]),
      .vram_sel_o(vramSel[0]), .vram_wr_o(vramWr[0]), .vram_mask_o(vramMask[0]),
      .vram_addr_o(vramAddr[0]), .vram_data_o(vramDataOut[0]), .vram_data_i(vramDataIn[0])
`ifdef VRAM_ARB_STATS_EN
      , .gfx_stall_cnt_o(stallCnt[0]), .forced_grant_cnt_o(forcedCnt[0])
`endif
   );

   vram_arbiter #(.READ_LATENCY(3)) dut3 (
      .clk(clk), .reset_i(reset_i),
      .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_ack_o(dispAck[1]),
      .disp_valid_o(dispValid[1]), .disp_data_o(dispData[1]),
      .gfx_sel_i(gfx_sel_i), .gfx_wr_i(gfx_wr_i), .gfx_mask_i(gfx_mask_i),
      .gfx_addr_i(gfx_addr_i), .gfx_data_i(gfx_data_i), .gfx_ack_o(gfxAck[1]),
      .gfx_valid_o(gfxValid[1]), .gfx_data_o(gfxData[1]),
      .vram_sel_o(vramSel[1]), .vram_wr_o(vramWr[1]), .vram_mask_o(vramMask[1]),
      .vram_addr_o(vramAddr[1]), .vram_data_o(vramDataOut[1]), .vram_data_i(vramDataIn[1])
`ifdef VRAM_ARB_STATS_EN
      , .gfx_stall_cnt_o(stallCnt[1]), .forced_grant_cnt_o(forcedCnt[1])
`endif
   );

   // Each mask bit covers one 4-bit nibble of the word.
   function automatic logic [DW-1:0] mergeMask(input logic [DW-1:0] oldW, input logic [DW-1:0] newW,
                                                input logic [MW-1:0] mask);
      logic [DW-1:0] r;
      r = oldW;
      for (int m = 0; m < MW; m++) begin
         if (mask[m]) r[m*4 +: 4] = newW[m*4 +: 4];
      end
      return r;
   endfunction

   // RAM models (1K words are enough for the addresses used), filled with
   // addr+0x100 on the first clock.
   logic [DW-1:0] ram [2][1024];
   logic [DW-1:0] rdPipe [2][4];
   logic          ramReady = 1'b0;

   always @(posedge clk) begin
      if (!ramReady) begin
         for (int i = 0; i < 2; i++)
            for (int a = 0; a < 1024; a++) ram[i][a] <= 16'(a) + 16'h0100;
         ramReady <= 1'b1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (vramSel[i] && vramWr[i])
               ram[i][vramAddr[i][9:0]] <= mergeMask(ram[i][vramAddr[i][9:0]], vramDataOut[i], vramMask[i]);
            rdPipe[i][0] <= (vramSel[i] && !vramWr[i]) ? ram[i][vramAddr[i][9:0]] : 16'hDEAD;
            for (int k = 1; k < 4; k++) rdPipe[i][k] <= rdPipe[i][k-1];
         end
      end
   end

   assign vramDataIn[0] = rdPipe[0][0];
   assign vramDataIn[1] = rdPipe[1][2];

   // Bench-side reference memory, updated from the stimulus at write acks.
   logic [DW-1:0] refMem [1024];
   initial for (int a = 0; a < 1024; a++) refMem[a] = 16'(a) + 16'h0100;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Scoreboard: [instance][0 = display, 1 = graphite]
   typedef struct packed {
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t expQ [2][2][$];

   logic          mV, mA, mRd;
   logic [DW-1:0] mD;
   logic [9:0]    mAddr;
   exp_t          mE;

   // Compare read returns and enqueue new reads; a reset throws away every
   // outstanding expectation because the DUT discards its in-flight tags.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 2; r++) begin
            mV    = (r == 0) ? dispValid[i] : gfxValid[i];
            mD    = (r == 0) ? dispData[i] : gfxData[i];
            mA    = (r == 0) ? dispAck[i] : gfxAck[i];
            mRd   = (r == 0) ? 1'b1 : !gfx_wr_i;
            mAddr = (r == 0) ? disp_addr_i[9:0] : gfx_addr_i[9:0];
            if (reset_i) begin
               expQ[i][r].delete();
            end else begin
               if (mV === 1'b1) begin
                  if (expQ[i][r].size() == 0) begin
                     total++;
                     bad++;
                     $display("[TB] FAIL unexpected_valid inst=%0d req=%0d: got valid data=%h, required no valid (cycle %0d)",
                              i, r, mD, cyc);
                  end else begin
                     mE = expQ[i][r].pop_front();
                     checkOutput($sformatf("ret_data inst=%0d req=%0d", i, r), 32'(mD), 32'(mE.data));
                     checkOutput($sformatf("ret_cycle inst=%0d req=%0d", i, r), cyc, mE.due);
                  end
               end else if (expQ[i][r].size() != 0 && expQ[i][r][0].due < cyc) begin
                  mE = expQ[i][r].pop_front();
                  total++;
                  bad++;
                  $display("[TB] FAIL missing_valid inst=%0d req=%0d: got none by cycle %0d, required data=%h at cycle %0d",
                           i, r, cyc, mE.data, mE.due);
               end
               if (mA === 1'b1 && mRd) begin
                  mE.data = refMem[mAddr];
                  mE.due  = cyc + 2 + ((i == 0) ? 1 : 3);
                  expQ[i][r].push_back(mE);
               end
            end
         end
      end
      if (!reset_i && gfxAck[0] === 1'b1 && gfx_wr_i)
         refMem[gfx_addr_i[9:0]] = mergeMask(refMem[gfx_addr_i[9:0]], gfx_data_i, gfx_mask_i);
   end

   task automatic applyStimulus(input logic rst, input logic dReq, input logic [AW-1:0] dAddr,
                                input logic gSel, input logic gWr, input logic [MW-1:0] gMask,
                                input logic [AW-1:0] gAddr, input logic [DW-1:0] gData);
      @(posedge clk);
      #1;
      reset_i     = rst;
      disp_req_i  = dReq;
      disp_addr_i = dAddr;
      gfx_sel_i   = gSel;
      gfx_wr_i    = gWr;
      gfx_mask_i  = gMask;
      gfx_addr_i  = gAddr;
      gfx_data_i  = gData;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
   endtask

   task automatic checkAcks(input string name, input logic eD, input logic eG);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("%s disp_ack inst=%0d", name, i), 32'(dispAck[i]), 32'(eD));
         checkOutput($sformatf("%s gfx_ack inst=%0d", name, i), 32'(gfxAck[i]), 32'(eG));
      end
   endtask

   task automatic checkResetValues(input string name);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("%s disp_valid %0d", name, i), 32'(dispValid[i]), 0);
         checkOutput($sformatf("%s gfx_valid %0d", name, i), 32'(gfxValid[i]), 0);
         checkOutput($sformatf("%s vram_sel %0d", name, i), 32'(vramSel[i]), 0);
         checkOutput($sformatf("%s vram_wr %0d", name, i), 32'(vramWr[i]), 0);
         checkOutput($sformatf("%s vram_mask %0d", name, i), 32'(vramMask[i]), 32'hF);
         checkOutput($sformatf("%s vram_addr %0d", name, i), 32'(vramAddr[i]), 0);
         checkOutput($sformatf("%s vram_data %0d", name, i), 32'(vramDataOut[i]), 0);
         checkOutput($sformatf("%s disp_data %0d", name, i), 32'(dispData[i]), 0);
         checkOutput($sformatf("%s gfx_data %0d", name, i), 32'(gfxData[i]), 0);
`ifdef VRAM_ARB_STATS_EN
         checkOutput($sformatf("%s stall_cnt %0d", name, i), stallCnt[i], 0);
         checkOutput($sformatf("%s forced_cnt %0d", name, i), 32'(forcedCnt[i]), 0);
`endif
      end
      checkAcks(name, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic          dReq;
      logic [AW-1:0] dAddr;
      logic          gSel;
      logic          gWr;
      logic [MW-1:0] gMask;
      logic [AW-1:0] gAddr;
      logic [DW-1:0] gData;
      logic          eDAck;
      logic          eGAck;
      logic          eSel;
      logic          eWr;
      logic [AW-1:0] eAddr;
      logic [MW-1:0] eMask;
   } vec_t;

   function automatic vec_t mkVec(logic dReq, logic [AW-1:0] dAddr, logic gSel, logic gWr,
                                  logic [MW-1:0] gMask, logic [AW-1:0] gAddr, logic [DW-1:0] gData,
                                  logic eDAck, logic eGAck, logic eSel, logic eWr,
                                  logic [AW-1:0] eAddr, logic [MW-1:0] eMask);
      vec_t v;
      v.dReq = dReq;   v.dAddr = dAddr; v.gSel = gSel;   v.gWr = gWr;
      v.gMask = gMask; v.gAddr = gAddr; v.gData = gData;
      v.eDAck = eDAck; v.eGAck = eGAck; v.eSel = eSel;   v.eWr = eWr;
      v.eAddr = eAddr; v.eMask = eMask;
      return v;
   endfunction

   vec_t vecs [14];
   int   forcedBefore;

   initial begin
      // dReq dAddr gSel gWr gMask gAddr gData | dAck gAck sel wr addr mask (command of previous row)
      vecs[0]  = mkVec(1, 14'h000, 0, 0, 4'h0, 14'h000, 16'h0000, 1, 0, 0, 0, 14'h000, 4'hF);
      vecs[1]  = mkVec(1, 14'h001, 0, 0, 4'h0, 14'h000, 16'h0000, 1, 0, 1, 0, 14'h000, 4'hF);
      vecs[2]  = mkVec(1, 14'h002, 0, 0, 4'h0, 14'h000, 16'h0000, 1, 0, 1, 0, 14'h001, 4'hF);
      vecs[3]  = mkVec(1, 14'h003, 0, 0, 4'h0, 14'h000, 16'h0000, 1, 0, 1, 0, 14'h002, 4'hF);
      vecs[4]  = mkVec(0, 14'h000, 0, 0, 4'h0, 14'h000, 16'h0000, 0, 0, 1, 0, 14'h003, 4'hF);
      vecs[5]  = mkVec(0, 14'h000, 1, 1, 4'hF, 14'h020, 16'hABCD, 0, 1, 0, 0, 14'h000, 4'hF);
      vecs[6]  = mkVec(0, 14'h000, 1, 0, 4'h5, 14'h020, 16'h0000, 0, 1, 1, 1, 14'h020, 4'hF);
      vecs[7]  = mkVec(0, 14'h000, 0, 0, 4'h0, 14'h000, 16'h0000, 0, 0, 1, 0, 14'h020, 4'hF);
      vecs[8]  = mkVec(1, 14'h005, 1, 0, 4'hF, 14'h030, 16'h0000, 1, 0, 0, 0, 14'h000, 4'hF);
      vecs[9]  = mkVec(0, 14'h000, 1, 0, 4'hF, 14'h030, 16'h0000, 0, 1, 1, 0, 14'h005, 4'hF);
      vecs[10] = mkVec(0, 14'h000, 1, 1, 4'h3, 14'h040, 16'h1234, 0, 1, 1, 0, 14'h030, 4'hF);
      vecs[11] = mkVec(0, 14'h000, 1, 0, 4'h3, 14'h040, 16'h0000, 0, 1, 1, 1, 14'h040, 4'h3);
      vecs[12] = mkVec(0, 14'h000, 0, 0, 4'h0, 14'h000, 16'h0000, 0, 0, 1, 0, 14'h040, 4'hF);
      vecs[13] = mkVec(0, 14'h000, 0, 0, 4'h0, 14'h000, 16'h0000, 0, 0, 0, 0, 14'h000, 4'hF);

      reset_i = 1'b1; disp_req_i = 1'b0; disp_addr_i = '0; gfx_sel_i = 1'b0;
      gfx_wr_i = 1'b0; gfx_mask_i = '0; gfx_addr_i = '0; gfx_data_i = '0;
      repeat (3) @(posedge clk);

      // Requests during reset must not be acked.
      applyStimulus(1'b1, 1'b1, 14'h011, 1'b1, 1'b0, 4'hF, 14'h012, '0);
      @(negedge clk);
      checkAcks("in_reset", 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      checkResetValues("after_reset");

      // Display burst, graphite write/read, tie-break and masked write.
      for (int v = 0; v < 14; v++) begin
         applyStimulus(1'b0, vecs[v].dReq, vecs[v].dAddr, vecs[v].gSel, vecs[v].gWr,
                       vecs[v].gMask, vecs[v].gAddr, vecs[v].gData);
         @(negedge clk);
         checkAcks($sformatf("vec%0d", v), vecs[v].eDAck, vecs[v].eGAck);
         for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("vec%0d vram_sel %0d", v, i), 32'(vramSel[i]), 32'(vecs[v].eSel));
            if (vecs[v].eSel) begin
               checkOutput($sformatf("vec%0d vram_wr %0d", v, i), 32'(vramWr[i]), 32'(vecs[v].eWr));
               checkOutput($sformatf("vec%0d vram_addr %0d", v, i), 32'(vramAddr[i]), 32'(vecs[v].eAddr));
               checkOutput($sformatf("vec%0d vram_mask %0d", v, i), 32'(vramMask[i]), 32'(vecs[v].eMask));
            end
         end
      end
      repeat (6) idleCycle();

      // Alternating display/graphite reads; latency 3 vs 5 checked by the scoreboard.
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) applyStimulus(1'b0, 1'b1, 14'(12'h100 + k), 1'b0, 1'b0, '0, '0, '0);
         else            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'hF, 14'(12'h200 + k), '0);
         @(negedge clk);
         checkAcks($sformatf("interleave%0d", k), k % 2 == 0, k % 2 == 1);
      end
      repeat (8) idleCycle();

      // Idle: no RAM strobes.
      for (int k = 0; k < 10; k++) begin
         idleCycle();
         for (int i = 0; i < 2; i++)
            checkOutput($sformatf("idle%0d vram_sel %0d", k, i), 32'(vramSel[i]), 0);
      end

      // Starvation bound: 8 display acks then 1 graphite ack, repeating,
      // starting from the counter cleared by the idle period.
`ifdef VRAM_ARB_STATS_EN
      forcedBefore = int'(forcedCnt[0]);
`else
      forcedBefore = 0;
`endif
      for (int j = 0; j < 27; j++) begin
         applyStimulus(1'b0, 1'b1, 14'(12'h050 + (j % 4)), 1'b1, 1'b0, 4'hF, 14'h060, '0);
         @(negedge clk);
         checkAcks($sformatf("burst%0d", j), (j % 9) != 8, (j % 9) == 8);
      end
`ifdef VRAM_ARB_STATS_EN
      checkOutput("forced_cnt delta", 32'(int'(forcedCnt[0]) - forcedBefore), 3);
`endif
      repeat (8) idleCycle();

      // Reset one cycle after a display read ack: that read never returns.
      applyStimulus(1'b0, 1'b1, 14'h007, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      checkAcks("midflight_ack", 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 14'h008, 1'b1, 1'b0, 4'hF, 14'h009, '0);
      @(negedge clk);
      checkAcks("midflight_reset", 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      checkResetValues("midflight_after");
      repeat (8) idleCycle();

      for (int i = 0; i < 2; i++)
         for (int r = 0; r < 2; r++)
            checkOutput($sformatf("drained inst=%0d req=%0d", i, r), expQ[i][r].size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
